// File: rtl/Tipos.sv
// Types and constants shared by the lock's keypad, setup and compare blocks.
package Tipos;

    localparam int unsigned PASS_DIGITS  = 20;
    localparam logic [3:0]  NIBBLE_EMPTY = 4'hF;
    localparam logic [3:0]  KEY_STAR     = 4'hA;
    localparam logic [3:0]  KEY_HASH     = 4'hB;

    typedef logic [PASS_DIGITS-1:0][3:0] senhaPac_t;

    localparam senhaPac_t PAC_EMPTY = {PASS_DIGITS{NIBBLE_EMPTY}};

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // Keys that count as user activity: digits, '*' and '#'.
    function automatic logic is_accepted(input logic [3:0] code);
        return code <= KEY_HASH;
    endfunction

endpackage

// File: rtl/key_collector_idle_timer.sv
// Inactivity timer: counts while run is high, flags the last cycle of the window.
module idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || !run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // A restart in the expiry cycle wins, so the pulse is suppressed.
    assign expired = run && !restart && (cnt == LAST);

endmodule

// File: rtl/key_collector.sv
// Keypad entry collector: assembles digits into a right-justified password packet.
module key_collector
    import Tipos::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic        clear_in,
    output logic [79:0] digitos_value,
    output logic        digitos_valid,
    output logic [79:0] entry_value,
    output logic [4:0]  entry_count,
    output logic        overflow,
    output logic        timeout
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [4:0] COUNT_MAX = 5'(PASS_DIGITS);

    state_t    state, state_n;
    senhaPac_t buffer, buffer_n;
    senhaPac_t packet, packet_n;
    logic [4:0] count, count_n;
    logic      valid_n, overflow_n, timeout_n;
    logic      key_accept, expired;

    assign key_accept = key_valid && !clear_in && is_accepted(key_code);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state != EMPTY),
        .restart(key_accept),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            buffer        <= PAC_EMPTY;
            packet        <= PAC_EMPTY;
            count         <= '0;
            digitos_valid <= 1'b0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_n;
            buffer        <= buffer_n;
            packet        <= packet_n;
            count         <= count_n;
            digitos_valid <= valid_n;
            overflow      <= overflow_n;
            timeout       <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state;
        buffer_n   = buffer;
        packet_n   = packet;
        count_n    = count;
        valid_n    = 1'b0;
        overflow_n = 1'b0;
        timeout_n  = 1'b0;

        if (clear_in) begin
            state_n  = EMPTY;
            buffer_n = PAC_EMPTY;
            count_n  = '0;
        end else if (key_accept) begin
            if (is_digit(key_code)) begin
                if (state == FULL) begin
                    overflow_n = 1'b1;
                end else begin
                    buffer_n = {buffer[PASS_DIGITS-2:0], key_code};
                    count_n  = count + 5'd1;
                    state_n  = (count_n == COUNT_MAX) ? FULL : COLLECT;
                end
            end else if (key_code == KEY_STAR) begin
                state_n  = EMPTY;
                buffer_n = PAC_EMPTY;
                count_n  = '0;
            end else if (state != EMPTY) begin
                packet_n = buffer;
                valid_n  = 1'b1;
                state_n  = EMPTY;
                buffer_n = PAC_EMPTY;
                count_n  = '0;
            end
        end else if (expired) begin
            state_n   = EMPTY;
            buffer_n  = PAC_EMPTY;
            count_n   = '0;
            timeout_n = 1'b1;
        end
    end

    assign digitos_value = packet;
    assign entry_value   = buffer;
    assign entry_count   = count;

endmodule

// File: tb/tb_key_collector.sv
// Directed self-checking bench for key_collector with a short inactivity window.
module tb_key_collector;

    localparam logic [79:0] ALL_F    = {20{4'hF}};
    localparam logic [79:0] PKT_1234 = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [79:0] PKT_OVF  = 80'h1234_5678_9012_3456_7890;
    localparam logic [79:0] PKT_8    = 80'hFFFF_FFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_code = 4'h0;
    logic        key_valid = 1'b0;
    logic        clear_in = 1'b0;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic [79:0] entry_value;
    logic [4:0]  entry_count;
    logic        overflow;
    logic        timeout;

    int unsigned tests = 0;
    int unsigned fails = 0;

    key_collector #(
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .clear_in     (clear_in),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid),
        .entry_value  (entry_value),
        .entry_count  (entry_count),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Drives one key for one cycle; returns at the negedge after the sampling edge.
    task automatic press(input logic [3:0] code);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (entry_value !== ALL_F || digitos_value !== ALL_F) begin
            fails++;
            $display("FAIL reset_buffers entry=%h value=%h expected=%h", entry_value, digitos_value, ALL_F);
        end
        tests++;
        if (entry_count !== 5'd0 || digitos_valid !== 1'b0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags count=%0d valid=%b ovf=%b tmo=%b expected 0", entry_count, digitos_valid, overflow, timeout);
        end
    endtask

    task automatic test_basic();
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        tests++;
        if (entry_count !== 5'd4 || entry_value !== PKT_1234) begin
            fails++;
            $display("FAIL basic_live count=%0d entry=%h expected 4 %h", entry_count, entry_value, PKT_1234);
        end
        press(4'hB);
        tests++;
        if (digitos_valid !== 1'b1 || digitos_value !== PKT_1234) begin
            fails++;
            $display("FAIL basic_emit valid=%b value=%h expected 1 %h", digitos_valid, digitos_value, PKT_1234);
        end
        tests++;
        if (entry_count !== 5'd0 || entry_value !== ALL_F) begin
            fails++;
            $display("FAIL basic_flush count=%0d entry=%h expected 0 %h", entry_count, entry_value, ALL_F);
        end
        @(negedge clk);
        tests++;
        if (digitos_valid !== 1'b0 || digitos_value !== PKT_1234) begin
            fails++;
            $display("FAIL basic_hold valid=%b value=%h expected 0 %h", digitos_valid, digitos_value, PKT_1234);
        end
    endtask

    task automatic test_empty_ignored();
        press(4'hB);
        tests++;
        if (digitos_valid !== 1'b0 || digitos_value !== PKT_1234 || entry_count !== 5'd0) begin
            fails++;
            $display("FAIL hash_empty valid=%b value=%h count=%0d expected 0 %h 0", digitos_valid, digitos_value, entry_count, PKT_1234);
        end
        press(4'h1);
        press(4'hD);
        tests++;
        if (entry_count !== 5'd1 || entry_value !== 80'hFFFF_FFFF_FFFF_FFFF_FFF1 || digitos_valid !== 1'b0) begin
            fails++;
            $display("FAIL ignored_key count=%0d entry=%h valid=%b expected 1 ..FFF1 0", entry_count, entry_value, digitos_valid);
        end
        press(4'hA);
        tests++;
        if (entry_count !== 5'd0 || entry_value !== ALL_F || digitos_value !== PKT_1234) begin
            fails++;
            $display("FAIL star_clear count=%0d entry=%h value=%h", entry_count, entry_value, digitos_value);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            press(4'((i + 1) % 10));
        end
        tests++;
        if (entry_count !== 5'd20 || entry_value !== PKT_OVF || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_20 count=%0d entry=%h ovf=%b expected 20 %h 0", entry_count, entry_value, overflow, PKT_OVF);
        end
        press(4'h7);
        tests++;
        if (overflow !== 1'b1 || entry_count !== 5'd20 || entry_value !== PKT_OVF) begin
            fails++;
            $display("FAIL overflow_21 ovf=%b count=%0d entry=%h expected 1 20 %h", overflow, entry_count, entry_value, PKT_OVF);
        end
        press(4'hB);
        tests++;
        if (overflow !== 1'b0 || digitos_valid !== 1'b1 || digitos_value !== PKT_OVF) begin
            fails++;
            $display("FAIL overflow_emit ovf=%b valid=%b value=%h expected 0 1 %h", overflow, digitos_valid, digitos_value, PKT_OVF);
        end
    endtask

    task automatic test_back_to_back();
        press(4'h5);
        press(4'h6);
        press(4'hA);
        press(4'h8);
        press(4'hB);
        tests++;
        if (digitos_valid !== 1'b1 || digitos_value !== PKT_8) begin
            fails++;
            $display("FAIL star_then_emit valid=%b value=%h expected 1 %h", digitos_valid, digitos_value, PKT_8);
        end
        // Digit in the cycle right after '#' starts a fresh entry.
        press(4'h9);
        tests++;
        if (entry_count !== 5'd1 || entry_value !== 80'hFFFF_FFFF_FFFF_FFFF_FFF9 || digitos_valid !== 1'b0) begin
            fails++;
            $display("FAIL next_entry count=%0d entry=%h valid=%b expected 1 ..FFF9 0", entry_count, entry_value, digitos_valid);
        end
        clear_in = 1'b1;
        press(4'hB);
        clear_in = 1'b0;
        tests++;
        if (digitos_valid !== 1'b0 || entry_count !== 5'd0 || entry_value !== ALL_F || digitos_value !== PKT_8) begin
            fails++;
            $display("FAIL clear_vs_hash valid=%b count=%0d entry=%h value=%h", digitos_valid, entry_count, entry_value, digitos_value);
        end
    endtask

    task automatic test_timeout();
        int unsigned early;
        early = 0;
        press(4'h3);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (timeout !== 1'b0) early++;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL timeout_early pulses=%0d expected 0", early);
        end
        @(negedge clk);
        tests++;
        if (timeout !== 1'b1 || entry_count !== 5'd0 || entry_value !== ALL_F) begin
            fails++;
            $display("FAIL timeout_pulse tmo=%b count=%0d entry=%h expected 1 0 %h", timeout, entry_count, entry_value, ALL_F);
        end
        @(negedge clk);
        tests++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_width tmo=%b expected 0", timeout);
        end
        // Second key lands exactly on the expiry cycle.
        press(4'h3);
        repeat (9) @(negedge clk);
        press(4'h4);
        tests++;
        if (timeout !== 1'b0 || entry_count !== 5'd2 || entry_value !== 80'hFFFF_FFFF_FFFF_FFFF_FF34) begin
            fails++;
            $display("FAIL key_on_expiry tmo=%b count=%0d entry=%h expected 0 2 ..FF34", timeout, entry_count, entry_value);
        end
        press(4'hA);
    endtask

    task automatic test_reset_mid_entry();
        int unsigned pulses;
        pulses = 0;
        press(4'h1);
        press(4'h2);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (entry_value !== ALL_F || digitos_value !== ALL_F || entry_count !== 5'd0) begin
            fails++;
            $display("FAIL async_reset entry=%h value=%h count=%0d expected all F and 0", entry_value, digitos_value, entry_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (digitos_valid !== 1'b0 || timeout !== 1'b0) pulses++;
        end
        tests++;
        if (pulses != 0 || entry_count !== 5'd0) begin
            fails++;
            $display("FAIL post_reset_quiet pulses=%0d count=%0d expected 0 0", pulses, entry_count);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_empty_ignored();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid_entry();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_collector.md
# key_collector

Keypad entry collector for the electronic lock. Accepts one decoded key code per press from the debounced keypad scanner. Assembles digits into a right-justified `senhaPac_t` password packet and emits it with a one-cycle `digitos_valid` pulse when the user presses `#`. It sits directly upstream of the `setup` block and the lock-compare logic, which consume `digitos_value`/`digitos_valid`.

## Interface
- `TIMEOUT_CYCLES`, 250_000_000: inactivity time (5 s at 50 MHz) after which a partial entry is discarded; legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_code`  in  4  key code: 0–9 digit, 4'hA `*`, 4'hB `#`, 4'hC–4'hF ignored.
- `key_valid`  in  1  one-cycle strobe, `key_code` meaningful only when high.
- `clear_in`  in  1  synchronous flush request from the main controller.
- `digitos_value`  out  80  last emitted packet (`senhaPac_t`), held until the next emission.
- `digitos_valid`  out  1  one-cycle strobe, packet valid.
- `entry_value`  out  80  live buffer, for the display block.
- `entry_count`  out  5  digits currently buffered, 0–20.
- `overflow`  out  1  one-cycle pulse when a digit is rejected because the buffer is full.
- `timeout`  out  1  one-cycle pulse when a partial entry is discarded by inactivity.

## Operation
- **Buffer format:** 20 nibbles, unused nibbles = 4'hF. The newest digit is in nibble 0; earlier digits shift toward the MSB. Entering 1,2,3,4 yields {16{4'hF},1,2,3,4}.
- **FSM states:** EMPTY (count 0), COLLECT (1–19), FULL (20).
- **Digit in EMPTY/COLLECT:** buffer <= {buffer[75:0], digit}; count+1. Reaching 20 moves to FULL.
- **Digit in FULL:** buffer unchanged; `overflow` pulses.
- **`#` in COLLECT/FULL:** `digitos_value` <= buffer; `digitos_valid` pulses. Buffer <= all F, count <= 0, next state EMPTY.
- **`#` in EMPTY:** no action, no pulse.
- **`*`:** clears the buffer to all F, count 0, EMPTY. `digitos_value` is untouched.
- **Codes 4'hC–4'hF:** ignored; the inactivity timer is not restarted.
- **Inactivity timer:** runs only outside EMPTY, restarts on every accepted key (digit, `*`, `#`). When it reaches `TIMEOUT_CYCLES-1`: clear the buffer, go to EMPTY, pulse `timeout`.
- **Priority within a cycle:** `clear_in` > `key_valid` > timer expiry.
  - `clear_in`: clears the buffer with no pulses, and any simultaneous key is dropped.
  - A key arriving in the same cycle as timer expiry is processed, and the timer restarts with no `timeout` pulse.
- **Arithmetic:** count is a 5-bit saturating value at 20. The timer width is $clog2(TIMEOUT_CYCLES).

## Timing
- **Reset values:**
  - `digitos_value` = `entry_value` = all 4'hF
  - `entry_count` = 0
  - `digitos_valid` = `overflow` = `timeout` = 0
  - FSM in EMPTY, timer 0
- **Reset mid-entry:** the partial entry is lost and no pulse is emitted.
- **Output registers:** all outputs are registered.
- **Latency:**
  - Key strobe at edge N updates `entry_value`/`entry_count` after edge N.
  - On `#`, `digitos_valid` is high for exactly the cycle following edge N.
  - `digitos_value` is already updated in that cycle and stays stable afterwards.
- **Back-to-back keys:** keys on consecutive cycles are all accepted, with no bubble needed.
- **Next entry after `#`:** a digit in the cycle right after `#` starts the next entry.
- **Timeout pulse:** `timeout` is high for one cycle, aligned with the buffer clearing.

## Structure
- **Shared package `Tipos.sv`:**
  - `senhaPac_t` (20×4-bit packed)
  - `PASS_DIGITS` = 20
  - `NIBBLE_EMPTY` = 4'hF
  - `KEY_STAR` = 4'hA
  - `KEY_HASH` = 4'hB
- **Local typedef:** FSM state enum.
- **Sub-module `idle_timer`:** parameter `TIMEOUT_CYCLES`; inputs `clk`, `rst`, `run`, `restart`; output `expired` (one-cycle pulse).

## Test plan
- **Basic entry:** keys 1,2,3,4,`#` -> one `digitos_valid` pulse, `digitos_value` = {16{4'hF},4'h1,4'h2,4'h3,4'h4}, then `entry_count` 0 and `entry_value` all F.
- **Empty and ignored keys:** `#` with empty buffer, and key 4'hD -> no pulse, buffer and `digitos_value` unchanged.
- **Overflow:** 21 digits (1..9,0 twice, then 7) -> `overflow` pulse on the 21st, count 20. A following `#` emits the first 20 digits only.
- **Clear and simultaneous events:** 5,6,`*`,8,`#` -> packet {19{4'hF},4'h8}. Separately, `clear_in` in the same cycle as `#` -> no pulse, buffer empty.
- **Timeout:** with `TIMEOUT_CYCLES`=10, digit 3 then idle -> `timeout` pulse 10 cycles after the key, buffer all F. A key landing on the expiry cycle -> no `timeout`, count increments.
- **Reset mid-entry:** `rst` asserted mid-entry after 2 digits -> all outputs return to reset values asynchronously. No `digitos_valid` follows.
